bp_stall_histogram: RTL

Consumer end of the per-cycle stall-reason encoding used by the BlackParrot profiler. Each cycle it accepts one 6-bit stall-reason code (0 = unknown … 32 = ic_miss), or a commit indication, and accumulates a per-reason histogram. It also keeps commit and total-cycle counters. The counters are read back by the host-facing shell one index at a time.

---
 rtl/bp_stall_histogram.sv | 109 ++++++++++
 1 files changed

// File: rtl/bp_stall_histogram.sv
// Per-cycle stall-reason histogram with commit and enabled-cycle counters.
// Saturating counters are read back one index at a time through a registered read port.
module bp_stall_histogram #(
  parameter int cnt_width_p   = 32,
  parameter int num_reasons_p = 33
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   en_i,
  input  logic                   clear_i,
  input  logic                   commit_v_i,
  input  logic                   stall_v_i,
  input  logic [5:0]             stall_reason_i,
  input  logic                   rd_v_i,
  input  logic [5:0]             rd_idx_i,
  output logic                   rd_v_o,
  output logic [cnt_width_p-1:0] rd_data_o,
  output logic                   overflow_o
);

  localparam int ComIdx = num_reasons_p;
  localparam int CycIdx = num_reasons_p + 1;
  localparam int NumCnt = num_reasons_p + 2;

  logic                   r_cyc_q;
  logic                   r_com_q;
  logic                   r_stl_q;
  logic [5:0]             r_rsn_q;
  logic [cnt_width_p-1:0] r_cnt [NumCnt];
  logic                   r_overflow;
  logic                   r_rd_v;
  logic [cnt_width_p-1:0] r_rd_data;

  logic [5:0]             w_rsn;
  logic [NumCnt-1:0]      w_inc;
  logic [NumCnt-1:0]      w_sat;
  logic [cnt_width_p-1:0] w_rd_data;

  // Out-of-range reasons are folded into the "unknown" bucket.
  assign w_rsn = (stall_reason_i > 6'(num_reasons_p - 1)) ? 6'd0 : stall_reason_i;

  always_comb begin
    w_inc = '0;
    w_sat = '0;
    for (int i = 0; i < num_reasons_p; i++) begin
      w_inc[i] = r_stl_q && (r_rsn_q == 6'(i));
    end
    w_inc[ComIdx] = r_com_q;
    w_inc[CycIdx] = r_cyc_q;
    for (int i = 0; i < NumCnt; i++) begin
      w_sat[i] = &r_cnt[i];
    end
  end

  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NumCnt; i++) begin
      if (rd_idx_i == 6'(i)) w_rd_data = r_cnt[i];
    end
  end

  // Clearing zeroes the counters at the same edge, which also drops the staged update.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_cyc_q    <= 1'b0;
      r_com_q    <= 1'b0;
      r_stl_q    <= 1'b0;
      r_rsn_q    <= '0;
      r_overflow <= 1'b0;
      for (int i = 0; i < NumCnt; i++) r_cnt[i] <= '0;
    end else if (clear_i) begin
      r_cyc_q    <= 1'b0;
      r_com_q    <= 1'b0;
      r_stl_q    <= 1'b0;
      r_overflow <= 1'b0;
      for (int i = 0; i < NumCnt; i++) r_cnt[i] <= '0;
    end else begin
      if (en_i) begin
        r_cyc_q <= 1'b1;
        r_com_q <= commit_v_i;
        r_stl_q <= stall_v_i & ~commit_v_i;
        r_rsn_q <= w_rsn;
      end else begin
        r_cyc_q <= 1'b0;
        r_com_q <= 1'b0;
        r_stl_q <= 1'b0;
      end
      for (int i = 0; i < NumCnt; i++) begin
        if (w_inc[i] && !w_sat[i]) r_cnt[i] <= r_cnt[i] + cnt_width_p'(1);
      end
      r_overflow <= r_overflow | (|(w_inc & w_sat));
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_rd_v    <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_rd_v <= rd_v_i;
      if (rd_v_i) r_rd_data <= w_rd_data;
    end
  end

  assign rd_v_o     = r_rd_v;
  assign rd_data_o  = r_rd_data;
  assign overflow_o = r_overflow;

endmodule
